mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of the attached RAM.
REQ-002 Parameter ADDRESS_WIDTH, default 12, RAM address width.
REQ-003 Parameter LEN_WIDTH, default 16, width of the word-count input.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a copy; sampled only in IDLE.
REQ-007 src_addr  input  ADDRESS_WIDTH  first source word address.
REQ-008 dst_addr  input  ADDRESS_WIDTH  first destination word address.
REQ-009 length  input  LEN_WIDTH  number of words to copy.
REQ-010 busy  output  1  high while a copy is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 ram_wEn  output  1  RAM write enable.
REQ-013 ram_addr  output  ADDRESS_WIDTH  RAM address.
REQ-014 ram_dataIn  output  DATA_WIDTH  RAM write data.
REQ-015 ram_dataOut  input  DATA_WIDTH  RAM registered read data.

Function
REQ-016 The block SHALL drive a single-port RAM with 1-cycle registered read: dataOut holds mem[addr] from the edge after addr is presented with wEn low, and is unchanged during write cycles.
REQ-017 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-018 IDLE: start high at an edge SHALL latch src_addr, dst_addr and length, clear the word index, and move to READ; if length==0, move to DONE instead.
REQ-019 READ: ram_addr SHALL be src+index and ram_wEn 0; next state WRITE.
REQ-020 WRITE: ram_addr SHALL be dst+index, ram_wEn 1, and ram_dataIn = ram_dataOut. Index increments; next state READ if index+1 < length, else DONE.
REQ-021 DONE: done SHALL be 1 for exactly this cycle; next state IDLE unconditionally.
REQ-022 busy SHALL be 1 exactly in READ and WRITE; a copy of L>0 words holds busy for 2L cycles.
REQ-023 start SHALL be ignored in READ, WRITE and DONE; inputs changing mid-copy SHALL have no effect.
REQ-024 In IDLE and DONE, ram_wEn, ram_addr and ram_dataIn SHALL be 0.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH; the index counter SHALL be LEN_WIDTH bits.
REQ-026 Words SHALL be copied in ascending index order. For overlapping regions with dst > src, the copy has forward-propagation semantics: each read returns the value currently in RAM.
REQ-027 ram_wEn SHALL never be high outside WRITE.

Reset
REQ-028 reset high at an edge SHALL force IDLE and clear the index and latched operands, with priority over start.
REQ-029 After reset, busy=0, done=0, ram_wEn=0, ram_addr=0 and ram_dataIn=0 from the following cycle.
REQ-030 Reset during a copy SHALL abort it with no further writes; already-written words remain, and no done pulse is produced.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit enum IDLE/READ/WRITE/DONE) and the default DATA_WIDTH/ADDRESS_WIDTH/LEN_WIDTH constants.
REQ-032 The block SHALL be a single module with no sub-module. RAM outputs SHALL be decoded combinationally from the state and registered operands.

Verification
REQ-033 RAM preloaded mem[i]=0x100+i for i=0..15; start with src=0, dst=0x40, length=4 -> mem[0x40..0x43]=0x100..0x103; busy high for 8 cycles; done pulses once in cycle 9.
REQ-034 length=0 -> no ram_wEn, busy never high, done pulses the cycle after start.
REQ-035 src=0xFFE, dst=0x010, length=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001 in that order; writes 0x010..0x013.
REQ-036 start pulsed again and operands changed mid-copy -> the original copy completes unchanged; a second copy is not started.
REQ-037 reset asserted in the 3rd WRITE of a 6-word copy -> outputs 0 the next cycle; exactly 2 or 3 destination words written; no done pulse; a new start then works normally.
REQ-038 Overlap: src=0, dst=1, length=3, mem[0..3]=A,B,C,D -> mem[1..3]=A,A,A.

Source files
------------

// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the word-by-word RAM copy engine:
// FSM state encoding and default bus widths.
package mem_copy_engine_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 12;
  localparam int DEF_LEN_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Copies length words from src_addr to dst_addr in a single-port RAM with registered read.
// Latency: 2 cycles per word (READ then WRITE), plus one DONE cycle; zero length gives DONE next cycle.
// Backpressure: none; start is only sampled in IDLE and the RAM is assumed always ready.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] src_addr,
  input  logic [ADDRESS_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] src_q;
  logic [ADDRESS_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     idx_q;
  logic [LEN_WIDTH-1:0]     idx_nxt;

  assign idx_nxt = idx_q + LEN_WIDTH'(1);

  // busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= length;
            idx_q <= '0;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              busy  <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WRITE;
        end
        WRITE: begin
          idx_q <= idx_nxt;
          if (idx_nxt < len_q) begin
            state <= READ;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The WRITE cycle forwards the word read in the preceding READ cycle straight back to the RAM.
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    case (state)
      READ: begin
        ram_addr = src_q + ADDRESS_WIDTH'(idx_q);
      end
      WRITE: begin
        ram_wEn    = 1'b1;
        ram_addr   = dst_q + ADDRESS_WIDTH'(idx_q);
        ram_dataIn = ram_dataOut;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: RAM model, per-cycle trace model of the copy, and directed plus random copies.
module tb_mem_copy_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] src_addr;
  logic [11:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;

  mem_copy_engine #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(12),
    .LEN_WIDTH    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_wEn    (ram_wEn),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read; init_req loads the whole image from ref_mem.
  logic [31:0] ram     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        init_req;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
    end else if (ram_wEn) begin
      ram[ram_addr] <= ram_dataIn;
    end else begin
      ram_dataOut <= ram[ram_addr];
    end
  end

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  localparam exp_t IDLE_EXP = '{busy: 1'b0, done: 1'b0, wen: 1'b0, addr: 12'h0, data: 32'h0, chk_data: 1'b1};

  exp_t exp_q[$];
  int   rd_ptr;
  exp_t e;
  logic ok;
  logic chk_en;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   lat;
  int   busy_cnt;
  int   wen_cnt;
  int   done_cnt;
  int   done_cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic mem_check(input string name);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int i = 0; i < 4096; i++) begin
      if (ram[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d words differ, first at %h got %h want %h",
               name, bad, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic load_img();
    @(posedge clk);
    #1 init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
  endtask

  task automatic clr_mon();
    busy_cnt = 0;
    wen_cnt  = 0;
    done_cnt = 0;
    done_cyc = 0;
  endtask

  // Builds the expected cycle trace of one copy, applying the first napply words to ref_mem.
  task automatic do_copy(input logic [11:0] s, input logic [11:0] d, input logic [15:0] l,
                         input int napply);
    logic [11:0] a_s;
    logic [11:0] a_d;
    logic [31:0] v;
    @(posedge clk);
    #1;
    exp_q.push_back(IDLE_EXP);
    for (int i = 0; i < int'(l); i++) begin
      a_s = s + 12'(i);
      a_d = d + 12'(i);
      v   = ref_mem[a_s];
      exp_q.push_back('{busy: 1'b1, done: 1'b0, wen: 1'b0, addr: a_s, data: 32'h0, chk_data: 1'b0});
      exp_q.push_back('{busy: 1'b1, done: 1'b0, wen: 1'b1, addr: a_d, data: v, chk_data: 1'b1});
      if (i < napply) ref_mem[a_d] = v;
    end
    exp_q.push_back('{busy: 1'b0, done: 1'b1, wen: 1'b0, addr: 12'h0, data: 32'h0, chk_data: 1'b1});
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = cyc;
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (done_cnt != 0) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done within 200 cycles want done pulse", name);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    init_req = 1'b0;
    chk_en   = 1'b0;
    rd_ptr   = 0;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    lat      = 0;
    clr_mon();
    for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h100 + i;
    ref_mem[12'hFFE] = 32'hCAFE0FFE;
    ref_mem[12'hFFF] = 32'hCAFE0FFF;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (chk_en) begin
          if (rd_ptr < exp_q.size()) begin
            e = exp_q[rd_ptr];
            rd_ptr++;
          end else begin
            e = IDLE_EXP;
          end
          ok = (busy === e.busy) && (done === e.done) && (ram_wEn === e.wen) &&
               (ram_addr === e.addr) && (!e.chk_data || (ram_dataIn === e.data));
          n_checks++;
          if (!ok) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t: got busy=%b done=%b wEn=%b addr=%h data=%h want busy=%b done=%b wEn=%b addr=%h data=%h",
                     $time, busy, done, ram_wEn, ram_addr, ram_dataIn,
                     e.busy, e.done, e.wen, e.addr, e.chk_data ? e.data : ram_dataIn);
          end
          if (busy === 1'b1) busy_cnt++;
          if (ram_wEn === 1'b1) wen_cnt++;
          if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc - lat + 1;
          end
        end
      end
      begin
        @(posedge clk);
        #1 chk_en = 1'b1;
        load_img();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic 4-word copy
        clr_mon();
        do_copy(12'h000, 12'h040, 16'd4, 4);
        wait_done("basic");
        check("basic_busy_cycles", busy_cnt, 32'd8);
        check("basic_done_cycle", done_cyc, 32'd9);
        check("basic_done_count", done_cnt, 32'd1);
        for (int i = 0; i < 4; i++) check("basic_dst_word", ram[12'h040 + i], 32'h100 + i);
        mem_check("basic_mem");

        // Zero length
        clr_mon();
        do_copy(12'h005, 12'h009, 16'd0, 0);
        wait_done("zero");
        check("zero_busy_cycles", busy_cnt, 32'd0);
        check("zero_writes", wen_cnt, 32'd0);
        check("zero_done_cycle", done_cyc, 32'd1);
        mem_check("zero_mem");

        // Source address wraps past the top of the RAM
        clr_mon();
        do_copy(12'hFFE, 12'h010, 16'd4, 4);
        wait_done("wrap");
        check("wrap_w0", ram[12'h010], 32'hCAFE0FFE);
        check("wrap_w1", ram[12'h011], 32'hCAFE0FFF);
        check("wrap_w2", ram[12'h012], 32'h100);
        check("wrap_w3", ram[12'h013], 32'h101);
        mem_check("wrap_mem");

        // start and operands disturbed mid-copy
        clr_mon();
        do_copy(12'h020, 12'h060, 16'd6, 6);
        repeat (3) @(posedge clk);
        #1;
        start    = 1'b1;
        src_addr = 12'h300;
        dst_addr = 12'h000;
        length   = 16'd2;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        wait_done("midcopy");
        check("midcopy_done_count", done_cnt, 32'd1);
        check("midcopy_busy_cycles", busy_cnt, 32'd12);
        mem_check("midcopy_mem");

        // Reset during the third WRITE of a 6-word copy
        clr_mon();
        do_copy(12'h100, 12'h200, 16'd6, 3);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        while (exp_q.size() > rd_ptr) void'(exp_q.pop_back());
        repeat (20) @(posedge clk);
        #1;
        check("abort_done_count", done_cnt, 32'd0);
        check("abort_writes", wen_cnt, 32'd3);
        mem_check("abort_mem");

        clr_mon();
        do_copy(12'h180, 12'h280, 16'd5, 5);
        wait_done("after_abort");
        check("after_abort_done_count", done_cnt, 32'd1);
        mem_check("after_abort_mem");

        // Overlapping forward copy
        ref_mem[0] = 32'hAAAA0000;
        ref_mem[1] = 32'hBBBB0001;
        ref_mem[2] = 32'hCCCC0002;
        ref_mem[3] = 32'hDDDD0003;
        load_img();
        clr_mon();
        do_copy(12'h000, 12'h001, 16'd3, 3);
        wait_done("overlap");
        for (int i = 0; i < 4; i++) check("overlap_word", ram[i], 32'hAAAA0000);
        mem_check("overlap_mem");

        // Random copies, overlaps included
        for (int t = 0; t < 8; t++) begin
          logic [11:0] rs;
          logic [11:0] rd;
          logic [15:0] rl;
          rs = 12'($urandom);
          rd = (t % 2 == 0) ? rs + 12'($urandom_range(0, 6)) : 12'($urandom);
          rl = 16'($urandom_range(1, 24));
          clr_mon();
          do_copy(rs, rd, rl, int'(rl));
          wait_done("random");
          check("random_busy_cycles", busy_cnt, 32'(2 * int'(rl)));
          mem_check("random_mem");
        end
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
